// File: rtl/fn_video_pkg.sv
// Shared video types for the sprite compositing path: colour, palette index and
// scheduler state encodings.
package fn_video_pkg;

    typedef logic [11:0] rgb12_t;
    typedef logic [7:0]  pal_idx_t;

    localparam rgb12_t KEY_RGB_DEFAULT = 12'hFBB;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sched_state_t;

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: position of the lowest set bit of a W-bit mask,
// plus a flag telling whether any bit is set.
module lowest_set_bit #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  mask,
    output logic [IW-1:0] index,
    output logic          any
);

    // NOTE: index gets a default before the loop so every path assigns it; without it a latch is inferred.
    always_comb begin
        index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) index = IW'(i);
        end
    end

    assign any = |mask;

endmodule

// File: rtl/palette_share_scheduler.sv
// Shares one combinational sprite palette among N_LAYERS requesters per pixel:
// scans valid layers in priority order, the first non-key colour wins, else background.
module palette_share_scheduler
    import fn_video_pkg::*;
#(
    parameter int     N_LAYERS = 4,
    parameter rgb12_t KEY_RGB  = KEY_RGB_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  pix_start,
    input  logic [N_LAYERS-1:0]   layer_valid,
    input  logic [N_LAYERS*8-1:0] layer_index,
    input  rgb12_t                bg_rgb,
    output pal_idx_t              pal_index,
    input  rgb12_t                pal_rgb,
    output rgb12_t                rgb_out,
    output logic                  rgb_valid,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int KW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    sched_state_t          state, state_nxt;
    logic [N_LAYERS-1:0]   pending_q;
    pal_idx_t              idx_q [N_LAYERS];
    rgb12_t                bg_q;
    pal_idx_t              pal_index_q;

    logic [KW-1:0]         k;
    logic                  any_pending;
    pal_idx_t              scan_idx;

    logic                  load, emit, drop_bit, set_ovr;
    rgb12_t                result;

    lowest_set_bit #(.W(N_LAYERS), .IW(KW)) u_lsb (
        .mask  (pending_q),
        .index (k),
        .any   (any_pending)
    );

    assign scan_idx  = idx_q[k];
    // Palette address follows the scan combinationally; outside a scan it parks on the last address used.
    assign pal_index = (state == SCAN && any_pending) ? scan_idx : pal_index_q;
    assign busy      = (state == SCAN);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        emit      = 1'b0;
        drop_bit  = 1'b0;
        set_ovr   = 1'b0;
        result    = bg_q;
        case (state)
            IDLE: begin
                if (pix_start) begin
                    load      = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                emit   = !any_pending || (pal_rgb != KEY_RGB);
                result = any_pending ? pal_rgb : bg_q;
                if (pix_start) begin
                    // A new pixel always wins; the old one is only lost if it had not decided yet.
                    load    = 1'b1;
                    set_ovr = !emit;
                end else if (emit) begin
                    state_nxt = IDLE;
                end else begin
                    drop_bit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the small index array is reset too, so a scan after reset never reads stale indices.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_q   <= '0;
            bg_q        <= '0;
            pal_index_q <= '0;
            rgb_out     <= '0;
            rgb_valid   <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < N_LAYERS; i++) idx_q[i] <= '0;
        end else begin
            rgb_valid <= emit;
            if (emit) rgb_out <= result;
            if (state == SCAN && any_pending) pal_index_q <= scan_idx;

            if (load) begin
                pending_q <= layer_valid;
                bg_q      <= bg_rgb;
                for (int i = 0; i < N_LAYERS; i++) idx_q[i] <= layer_index[8*i +: 8];
            end else if (drop_bit) begin
                pending_q[k] <= 1'b0;
            end

            if (set_ovr)          overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

endmodule
